spi_xfer_ctrl: RTL and testbench
================================

// Module: spi_xfer_ctrl
// PURPOSE
//  Master-mode SPI transfer sequencer and baud generator that drives spi_shift_reg.
//  Per transfer it sequences slave-select, the TX load strobe, SCLK, the four
//  edge-qualifier pulses consumed by the shift register, and the RX-valid strobe.
//  Sits between the APB register file (start/config) and spi_shift_reg plus pads.
// PARAMETERS
//  DATA_BITS  8   bits per frame; SCLK edges per frame = 2*DATA_BITS
//  CNT_W      11  width of the half-period counter (max half-period 1024 PCLK)
// PORTS
//  PCLK                  in   1  system clock, all logic on rising edge
//  PRESET_n              in   1  asynchronous active-low reset
//  spe_i                 in   1  SPI enable; low aborts any transfer
//  start_i               in   1  request one frame; honoured only in IDLE with spe_i=1
//  cpol_i                in   1  SCLK idle level
//  cpha_i                in   1  clock phase (0: sample on leading edge)
//  sppr_i                in   3  baud pre-selector
//  spr_i                 in   3  baud selector
//  ss_o                  out  1  slave select, active low
//  sclk_o                out  1  serial clock to pad
//  send_data_o           out  1  1-cycle TX load strobe to shift register
//  receive_data_o        out  1  1-cycle RX-valid strobe to shift register
//  mosi_send_sclk_o      out  1  pulse in the cycle before each SCLK falling edge
//  mosi_send_sclk0_o     out  1  pulse in the cycle before each SCLK rising edge
//  miso_receive_sclk_o   out  1  pulse in the cycle before each SCLK rising edge
//  miso_receive_sclk0_o  out  1  pulse in the cycle before each SCLK falling edge
//  busy_o                out  1  high from LOAD through DONE inclusive
//  done_o                out  1  1-cycle completion pulse, coincident with receive_data_o
// BEHAVIOUR
//  Reset: ss_o=1, sclk_o=0, busy_o=0, all strobes/pulses 0, FSM=IDLE, counters 0.
//  Half-period H = (sppr_i+1) << spr_i PCLK cycles (1..1024), computed CNT_W wide.
//  cpol/cpha/sppr/spr are latched in LOAD; later changes ignored until next frame.
//  IDLE:  ss_o=1, sclk_o follows cpol_i. start_i&spe_i -> LOAD. start_i while busy ignored.
//  LOAD:  1 cycle; send_data_o=1, ss_o=0 -> LEAD.
//  LEAD:  sclk_o=cpol; wait H cycles (setup). cpha=0: one mosi send pulse (sclk or
//         sclk0 set per mode rule below) in the last LEAD cycle puts bit 0 on MOSI. -> XFER.
//  XFER:  half-period counter counts 0..H-1; at H-1 sclk_o toggles next cycle,
//         edge counter increments, counter wraps to 0. Pulses asserted in the H-1 cycle
//         per the upcoming edge direction. After 2*DATA_BITS toggles -> TRAIL.
//  Pulse selection: modes 0/3 (cpol==cpha) use *_sclk_o; modes 1/2 use *_sclk0_o;
//         the unused pair stays 0. Send pulses only on shift edges, receive pulses
//         only on sample edges (cpha=0: sample leading, shift trailing; cpha=1 reverse).
//  cpha=0: final trailing-edge send pulse is suppressed -> exactly DATA_BITS send
//         pulses and DATA_BITS receive pulses per frame in every mode.
//  TRAIL: sclk_o=cpol, ss_o=0 held H cycles (hold time). -> DONE.
//  DONE:  1 cycle; receive_data_o=1, done_o=1, ss_o=1 -> IDLE.
//  Abort: spe_i=0 in any non-IDLE state -> IDLE next cycle, ss_o=1, sclk_o=cpol,
//         no receive_data_o/done_o, counters cleared.
//  H=1: pulses may assert on consecutive cycles; no edge may be skipped.
//  Async reset mid-frame: all outputs to reset values immediately.
// TESTING
//  Mode 0, sppr=0 spr=0 (H=1), start 1 cycle -> send_data_o@LOAD, 16 sclk_o toggles,
//   8 mosi_send_sclk_o and 8 miso_receive_sclk_o pulses, *_sclk0_o never high, done_o once.
//  Mode 1, sppr=2 spr=1 (H=6) -> sclk period 12 PCLK, first edge rising, 8 mosi_send_sclk0_o
//   each 1 cycle before a rise, 8 miso_receive_sclk0_o before falls; ss_o low 6 cycles pre/post.
//  Mode 3 loopback MISO=MOSI with spi_shift_reg, data 8'hA5, MSB first -> data_miso=8'hA5
//   in the receive_data_o cycle.
//  Max divider sppr=7 spr=7 (H=1024) -> exactly 1024 PCLK between sclk_o edges, no overflow.
//  spe_i dropped after 5th edge -> ss_o=1 next cycle, sclk_o=cpol, no done_o; new start works.
//  start_i held high through frame, cpol toggled mid-frame -> one frame only per start
//   accepted in IDLE, sclk_o unaffected until IDLE.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// spi_xfer_ctrl
//   Master-mode SPI frame sequencer and baud generator. For each accepted
//   start request it asserts slave select, strobes the TX load into the shift
//   register, generates 2*DATA_BITS SCLK edges at the programmed half period,
//   issues the edge-qualifier pulses the shift register uses to drive MOSI and
//   sample MISO, then releases slave select and strobes RX-valid / done.
//
// Parameters
//   DATA_BITS  bits per frame (SCLK edges per frame = 2*DATA_BITS)
//   CNT_W      half-period counter width (half period up to 1024 PCLK)
//
// Ports
//   PCLK                  in   system clock, rising edge
//   PRESET_n              in   asynchronous active-low reset
//   spe_i                 in   SPI enable; low aborts a frame in progress
//   start_i               in   request one frame (taken only in idle with spe_i)
//   cpol_i                in   SCLK idle level
//   cpha_i                in   clock phase (0: sample on leading edge)
//   sppr_i                in   baud pre-selector
//   spr_i                 in   baud selector
//   ss_o                  out  slave select, active low
//   sclk_o                out  serial clock
//   send_data_o           out  1-cycle TX load strobe
//   receive_data_o        out  1-cycle RX-valid strobe
//   mosi_send_sclk_o      out  shift pulse, cycle before an SCLK fall (modes 0/3)
//   mosi_send_sclk0_o     out  shift pulse, cycle before an SCLK rise (modes 1/2)
//   miso_receive_sclk_o   out  sample pulse, cycle before an SCLK rise (modes 0/3)
//   miso_receive_sclk0_o  out  sample pulse, cycle before an SCLK fall (modes 1/2)
//   busy_o                out  high from load through done
//   done_o                out  1-cycle completion pulse
// ---------------------------------------------------------------------------
module spi_xfer_ctrl #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned CNT_W     = 11
) (
    input  logic       PCLK,
    input  logic       PRESET_n,
    input  logic       spe_i,
    input  logic       start_i,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic [2:0] sppr_i,
    input  logic [2:0] spr_i,
    output logic       ss_o,
    output logic       sclk_o,
    output logic       send_data_o,
    output logic       receive_data_o,
    output logic       mosi_send_sclk_o,
    output logic       mosi_send_sclk0_o,
    output logic       miso_receive_sclk_o,
    output logic       miso_receive_sclk0_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned EDGE_W = $clog2(2 * DATA_BITS);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLead,
        StXfer,
        StTrail,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   half_m1_q, half_m1_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;
    logic               sclk_q, sclk_d;
    logic               cpol_q, cpol_d;
    logic               cpha_q, cpha_d;

    logic [CNT_W-1:0]   half_calc;
    logic               last_half;
    logic               leading;
    logic               use_main;
    logic               send_evt;
    logic               recv_evt;

    // Half period H = (sppr+1) << spr; at most 8 << 7 = 1024, fits CNT_W bits.
    assign half_calc = (CNT_W'(sppr_i) + CNT_W'(1)) << spr_i;

    assign last_half = (cnt_q == half_m1_q);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            half_m1_q <= '0;
            edge_q    <= '0;
            sclk_q    <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_m1_q <= half_m1_d;
            edge_q    <= edge_d;
            sclk_q    <= sclk_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        half_m1_d = half_m1_q;
        edge_d    = edge_q;
        sclk_d    = sclk_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;

        case (state_q)
            StIdle: begin
                // Idle clock level tracks the live cpol setting.
                sclk_d = cpol_i;
                cnt_d  = '0;
                edge_d = '0;
                if (start_i && spe_i) begin
                    state_d = StLoad;
                end
            end

            StLoad: begin
                // Frame configuration is frozen here for the whole frame.
                cpol_d    = cpol_i;
                cpha_d    = cpha_i;
                half_m1_d = half_calc - CNT_W'(1);
                sclk_d    = cpol_i;
                cnt_d     = '0;
                edge_d    = '0;
                state_d   = StLead;
            end

            StLead: begin
                if (last_half) begin
                    cnt_d   = '0;
                    state_d = StXfer;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StXfer: begin
                if (last_half) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    if (edge_q == LAST_EDGE) begin
                        // Final edge returns SCLK to the idle level.
                        edge_d  = '0;
                        state_d = StTrail;
                    end else begin
                        edge_d = edge_q + EDGE_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StTrail: begin
                if (last_half) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            StDone: begin
                sclk_d  = cpol_q;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything; in load the latched cpol is not yet valid.
        if (!spe_i && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_d   = '0;
            edge_d  = '0;
            sclk_d  = (state_q == StLoad) ? cpol_i : cpol_q;
        end
    end

    // ------------------------------------------------------------------
    // Edge-qualifier pulse decode
    // ------------------------------------------------------------------
    always_comb begin
        // Even edge index is a leading edge (first edge away from idle level).
        leading  = ~edge_q[0];
        // Modes 0/3 use the *_sclk pair, modes 1/2 the *_sclk0 pair.
        use_main = (cpol_q == cpha_q);
        send_evt = 1'b0;
        recv_evt = 1'b0;

        if ((state_q == StLead) && last_half && !cpha_q) begin
            // cpha=0: first bit must be on MOSI before the first (sampling) edge.
            send_evt = 1'b1;
        end

        if ((state_q == StXfer) && last_half) begin
            if (cpha_q) begin
                send_evt = leading;
                recv_evt = ~leading;
            end else begin
                // Last trailing edge would shift a ninth bit; suppress it.
                send_evt = ~leading && (edge_q != LAST_EDGE);
                recv_evt = leading;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        ss_o                 = 1'b1;
        busy_o               = (state_q != StIdle);
        sclk_o               = sclk_q;
        send_data_o          = spe_i && (state_q == StLoad);
        receive_data_o       = spe_i && (state_q == StDone);
        done_o               = spe_i && (state_q == StDone);
        mosi_send_sclk_o     = spe_i && send_evt && use_main;
        mosi_send_sclk0_o    = spe_i && send_evt && !use_main;
        miso_receive_sclk_o  = spe_i && recv_evt && use_main;
        miso_receive_sclk0_o = spe_i && recv_evt && !use_main;

        if ((state_q == StLoad) || (state_q == StLead) ||
            (state_q == StXfer) || (state_q == StTrail)) begin
            ss_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
module tb_spi_xfer_ctrl;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 11;

    logic       PCLK     = 1'b0;
    logic       PRESET_n = 1'b0;
    logic       spe_i, start_i, cpol_i, cpha_i;
    logic [2:0] sppr_i, spr_i;
    logic       ss_o, sclk_o, send_data_o, receive_data_o;
    logic       mosi_send_sclk_o, mosi_send_sclk0_o;
    logic       miso_receive_sclk_o, miso_receive_sclk0_o;
    logic       busy_o, done_o;

    spi_xfer_ctrl #(
        .DATA_BITS(DATA_BITS),
        .CNT_W    (CNT_W)
    ) dut (
        .PCLK                (PCLK),
        .PRESET_n            (PRESET_n),
        .spe_i               (spe_i),
        .start_i             (start_i),
        .cpol_i              (cpol_i),
        .cpha_i              (cpha_i),
        .sppr_i              (sppr_i),
        .spr_i               (spr_i),
        .ss_o                (ss_o),
        .sclk_o              (sclk_o),
        .send_data_o         (send_data_o),
        .receive_data_o      (receive_data_o),
        .mosi_send_sclk_o    (mosi_send_sclk_o),
        .mosi_send_sclk0_o   (mosi_send_sclk0_o),
        .miso_receive_sclk_o (miso_receive_sclk_o),
        .miso_receive_sclk0_o(miso_receive_sclk0_o),
        .busy_o              (busy_o),
        .done_o              (done_o)
    );

    always #5 PCLK = ~PCLK;

    // Expected per-frame observation; -1 means "not checked".
    typedef struct {
        int toggles;
        int mosi_main;
        int mosi_alt;
        int miso_main;
        int miso_alt;
        int al_send;
        int al_recv;
        int gap;
        int hold;
        int sends;
        int recvs;
        int dones;
        int end_sclk;
        int rx;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   frames   = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_opt(input string name, input int act, input int req);
        if (req >= 0) chk(name, act, req);
    endtask

    task automatic push_exp(input exp_t e);
        exp_q.push_back(e);
        pushed++;
    endtask

    function automatic exp_t normal_exp(input bit cpol, input bit cpha, input int h,
                                        input int data);
        exp_t e;
        bit   m;
        m           = (cpol == cpha);
        e.toggles   = 2 * DATA_BITS;
        e.mosi_main = m ? DATA_BITS : 0;
        e.mosi_alt  = m ? 0 : DATA_BITS;
        e.miso_main = m ? DATA_BITS : 0;
        e.miso_alt  = m ? 0 : DATA_BITS;
        // cpha=0: the pre-edge send pulse in lead is not followed by an edge.
        e.al_send   = cpha ? DATA_BITS : DATA_BITS - 1;
        e.al_recv   = DATA_BITS;
        e.gap       = h;
        e.hold      = h;
        e.sends     = 1;
        e.recvs     = 1;
        e.dones     = 1;
        e.end_sclk  = int'(cpol);
        e.rx        = data;
        return e;
    endfunction

    // Behavioural loopback shift register (MISO tied to MOSI), MSB first.
    logic [7:0] tx_data;
    logic [7:0] tx_sh, rx_sh;
    logic       mosi_q;

    always @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            tx_sh  <= '0;
            rx_sh  <= '0;
            mosi_q <= 1'b0;
        end else begin
            if (send_data_o) begin
                tx_sh <= tx_data;
            end else if (mosi_send_sclk_o || mosi_send_sclk0_o) begin
                mosi_q <= tx_sh[7];
                tx_sh  <= {tx_sh[6:0], 1'b0};
            end
            if (miso_receive_sclk_o || miso_receive_sclk0_o) begin
                rx_sh <= {rx_sh[6:0], mosi_q};
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: accumulates per-frame activity, compares at frame end.
    // ------------------------------------------------------------------
    int   m_idx = 0;
    logic pb = 1'b0, ps = 1'b0;
    logic p_ms = 1'b0, p_ms0 = 1'b0, p_mr = 1'b0, p_mr0 = 1'b0;
    int   m_tog, m_ms, m_ms0, m_mr, m_mr0, m_als, m_alr;
    int   m_gmin, m_gmax, m_last, m_rise, m_send, m_recv, m_done, m_rx;
    exp_t m_e;

    task automatic mon_clear();
        m_tog = 0; m_ms = 0; m_ms0 = 0; m_mr = 0; m_mr0 = 0; m_als = 0; m_alr = 0;
        m_gmin = 1 << 30; m_gmax = 0; m_last = -1; m_rise = -1;
        m_send = 0; m_recv = 0; m_done = 0; m_rx = -1;
    endtask

    initial begin
        mon_clear();
        forever begin
            @(negedge PCLK);
            m_idx++;
            if (busy_o) begin
                if (pb && (sclk_o !== ps)) begin
                    m_tog++;
                    if (m_last >= 0) begin
                        if (m_idx - m_last < m_gmin) m_gmin = m_idx - m_last;
                        if (m_idx - m_last > m_gmax) m_gmax = m_idx - m_last;
                    end
                    m_last = m_idx;
                    if (sclk_o) begin
                        if (p_ms0) m_als++;
                        if (p_mr)  m_alr++;
                    end else begin
                        if (p_ms)  m_als++;
                        if (p_mr0) m_alr++;
                    end
                end
                if (mosi_send_sclk_o)     m_ms++;
                if (mosi_send_sclk0_o)    m_ms0++;
                if (miso_receive_sclk_o)  m_mr++;
                if (miso_receive_sclk0_o) m_mr0++;
                if (send_data_o)          m_send++;
                if (done_o)               m_done++;
                if (receive_data_o) begin
                    m_recv++;
                    m_rx = int'(rx_sh);
                end
                if (ss_o && (m_rise < 0)) m_rise = m_idx;
            end else if (pb) begin
                frames++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk_opt("sclk_toggles", m_tog, m_e.toggles);
                    chk_opt("mosi_send_sclk", m_ms, m_e.mosi_main);
                    chk_opt("mosi_send_sclk0", m_ms0, m_e.mosi_alt);
                    chk_opt("miso_receive_sclk", m_mr, m_e.miso_main);
                    chk_opt("miso_receive_sclk0", m_mr0, m_e.miso_alt);
                    chk_opt("send_pulse_before_edge", m_als, m_e.al_send);
                    chk_opt("recv_pulse_before_edge", m_alr, m_e.al_recv);
                    chk_opt("send_data_count", m_send, m_e.sends);
                    chk_opt("receive_data_count", m_recv, m_e.recvs);
                    chk_opt("done_count", m_done, m_e.dones);
                    chk_opt("end_sclk", int'(sclk_o), m_e.end_sclk);
                    chk("end_ss", int'(ss_o), 1);
                    if (m_e.gap >= 0) begin
                        chk("half_period_min", m_gmin, m_e.gap);
                        chk("half_period_max", m_gmax, m_e.gap);
                    end
                    if (m_e.hold >= 0) chk("ss_hold", m_rise - m_last, m_e.hold);
                    chk_opt("loopback_rx", m_rx, m_e.rx);
                end
                mon_clear();
            end
            pb    = busy_o;
            ps    = sclk_o;
            p_ms  = mosi_send_sclk_o;
            p_ms0 = mosi_send_sclk0_o;
            p_mr  = miso_receive_sclk_o;
            p_mr0 = miso_receive_sclk0_o;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy_o && (n < budget)) begin
            tick(1);
            n++;
        end
        chk(name, int'(busy_o), 0);
    endtask

    task automatic setup(input bit cpol, input bit cpha, input int sppr, input int spr,
                         input int data);
        cpol_i  = cpol;
        cpha_i  = cpha;
        sppr_i  = 3'(sppr);
        spr_i   = 3'(spr);
        tx_data = 8'(data);
        tick(2);
    endtask

    task automatic run_frame(input bit cpol, input bit cpha, input int sppr, input int spr,
                             input int data);
        int h;
        h = (sppr + 1) << spr;
        setup(cpol, cpha, sppr, spr, data);
        push_exp(normal_exp(cpol, cpha, h, data));
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        wait_idle((2 * DATA_BITS + 4) * h + 20, "frame_timeout");
        tick(3);
    endtask

    initial begin
        exp_t e;
        int   n;
        int   cnt;
        logic prev;

        spe_i   = 1'b1;
        start_i = 1'b0;
        cpol_i  = 1'b0;
        cpha_i  = 1'b0;
        sppr_i  = '0;
        spr_i   = '0;
        tx_data = '0;

        // Reset state
        tick(3);
        chk("reset_ss", int'(ss_o), 1);
        chk("reset_sclk", int'(sclk_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_send_data", int'(send_data_o), 0);
        chk("reset_done", int'(done_o), 0);
        chk("reset_pulses", int'(mosi_send_sclk_o | mosi_send_sclk0_o |
                                 miso_receive_sclk_o | miso_receive_sclk0_o), 0);
        @(negedge PCLK);
        PRESET_n = 1'b1;
        tick(2);

        // Mode 0, H=1; mode 1, H=6; mode 3, H=2; mode 2, H=4
        run_frame(1'b0, 1'b0, 0, 0, 8'h3C);
        run_frame(1'b0, 1'b1, 2, 1, 8'h5A);
        run_frame(1'b1, 1'b1, 1, 0, 8'hA5);
        run_frame(1'b1, 1'b0, 0, 2, 8'hC3);

        // Maximum divider, H=1024
        run_frame(1'b0, 1'b0, 7, 7, 8'h81);

        // Abort after the fifth SCLK edge (mode 0, H=3)
        setup(1'b0, 1'b0, 2, 0, 8'hF0);
        e = '{toggles: 5, mosi_main: 3, mosi_alt: 0, miso_main: 3, miso_alt: 0,
              al_send: 2, al_recv: 3, gap: 3, hold: -1, sends: 1, recvs: 0, dones: 0,
              end_sclk: 0, rx: -1};
        push_exp(e);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        n    = 0;
        cnt  = 0;
        prev = sclk_o;
        while ((cnt < 5) && (n < 500)) begin
            tick(1);
            n++;
            if (busy_o && (sclk_o !== prev)) cnt++;
            prev = sclk_o;
        end
        chk("abort_fifth_edge_reached", cnt, 5);
        spe_i = 1'b0;
        tick(1);
        chk("abort_ss", int'(ss_o), 1);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_sclk", int'(sclk_o), 0);
        tick(2);
        spe_i = 1'b1;
        tick(2);
        run_frame(1'b0, 1'b0, 0, 0, 8'h5C);

        // start held through the frame, cpol changed mid-frame (mode 0, H=2)
        setup(1'b0, 1'b0, 1, 0, 8'h69);
        push_exp(normal_exp(1'b0, 1'b0, 2, 8'h69));
        start_i = 1'b1;
        tick(10);
        cpol_i = 1'b1;
        n = 0;
        while (!done_o && (n < 200)) begin
            tick(1);
            n++;
        end
        chk("held_done_seen", int'(done_o), 1);
        start_i = 1'b0;
        tick(1);
        chk("held_first_idle_sclk", int'(sclk_o), 0);
        tick(1);
        chk("held_idle_follows_cpol", int'(sclk_o), 1);
        cpol_i = 1'b0;
        tick(5);
        chk("held_single_frame", int'(busy_o), 0);

        // Asynchronous reset mid-frame (mode 3, H=2)
        setup(1'b1, 1'b1, 1, 0, 8'hA5);
        e = '{toggles: -1, mosi_main: -1, mosi_alt: -1, miso_main: -1, miso_alt: -1,
              al_send: -1, al_recv: -1, gap: -1, hold: -1, sends: -1, recvs: 0, dones: 0,
              end_sclk: 0, rx: -1};
        push_exp(e);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(15);
        PRESET_n = 1'b0;
        #1;
        chk("midreset_ss", int'(ss_o), 1);
        chk("midreset_sclk", int'(sclk_o), 0);
        chk("midreset_busy", int'(busy_o), 0);
        chk("midreset_pulses", int'(mosi_send_sclk_o | mosi_send_sclk0_o |
                                    miso_receive_sclk_o | miso_receive_sclk0_o), 0);
        repeat (2) @(negedge PCLK);
        PRESET_n = 1'b1;
        tick(2);
        run_frame(1'b0, 1'b0, 0, 0, 8'h96);

        tick(5);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("frame_count", frames, pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
